// File: rtl/data_memory_if.sv
// Load/store request and response bundle between the memory stage and data_memory.
// The memory drives the "slave" modport; the requester and response consumer drive "master".
interface data_memory_if #(
    parameter int unsigned DATA_WIDTH_P = 32,
    parameter int unsigned ADDR_WIDTH_P = 32
);
    logic                    i_req_valid;
    logic                    o_req_ready;
    logic                    i_req_we;
    logic [ADDR_WIDTH_P-1:0] i_req_addr;
    logic [1:0]              i_req_size;
    logic                    i_req_unsigned;
    logic [DATA_WIDTH_P-1:0] i_req_wdata;
    logic                    o_rsp_valid;
    logic                    i_rsp_ready;
    logic [DATA_WIDTH_P-1:0] o_rsp_rdata;
    logic                    o_rsp_err;

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_unsigned, i_req_wdata,
        output i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_unsigned, i_req_wdata,
        input  i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );
endinterface

// File: rtl/data_memory.sv
// Byte-addressable data memory with sub-word stores/loads and a one-entry response register.
// Optional DATA_MEMORY_MISALIGN_ERR_EN: fault misaligned accesses instead of aligning them down.
module data_memory #(
    parameter int unsigned DATA_WIDTH_P = 32,
    parameter int unsigned ADDR_WIDTH_P = 32,
    parameter int unsigned DEPTH_P      = 1024
) (
    input  logic           clk,
    input  logic           reset,
    data_memory_if.slave   bus
);
    localparam int unsigned LANES   = DATA_WIDTH_P / 8;
    localparam int unsigned LANE_W  = $clog2(LANES);
    localparam int unsigned NB_W    = LANE_W + 1;
    localparam int unsigned DEPTH_W = $clog2(DEPTH_P);
    localparam logic [ADDR_WIDTH_P-1:0] DEPTH_A = ADDR_WIDTH_P'(DEPTH_P);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH_P-1:0] mem [DEPTH_P];

    logic                    accept;
    logic [ADDR_WIDTH_P-1:0] word_idx;
    logic [LANE_W-1:0]       offset;
    logic [LANE_W-1:0]       size_mask;
    logic [LANE_W-1:0]       eff_off;
    logic [NB_W-1:0]         nbytes;
    logic                    size_ok;
    logic                    out_of_range;
    logic                    fault;
    logic                    wr_en;
    logic [LANES-1:0]        lane_en;
    logic [DATA_WIDTH_P-1:0] wdata_sh;
    logic [DATA_WIDTH_P-1:0] rword;
    logic [DATA_WIDTH_P-1:0] rword_sh;
    logic [DATA_WIDTH_P-1:0] load_data;
    logic                    sign_bit;
    logic                    fill;
    logic [DATA_WIDTH_P-1:0] rsp_rdata;
    logic                    rsp_err;

    // Address decode, legality and alignment of the presented request.
    always_comb begin
        word_idx     = bus.i_req_addr >> LANE_W;
        offset       = bus.i_req_addr[LANE_W-1:0];
        nbytes       = NB_W'(1) << bus.i_req_size;
        size_mask    = LANE_W'(nbytes - NB_W'(1));
        size_ok      = 32'(bus.i_req_size) <= LANE_W;
        out_of_range = word_idx >= DEPTH_A;
`ifdef DATA_MEMORY_MISALIGN_ERR_EN
        eff_off      = offset;
        fault        = out_of_range || !size_ok || ((offset & size_mask) != '0);
`else
        eff_off      = offset & ~size_mask;
        fault        = out_of_range || !size_ok;
`endif
    end

    // Store lane mask and lane-aligned store data.
    always_comb begin
        lane_en = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_en[l] = (l >= int'(eff_off)) && (l < int'(eff_off) + int'(nbytes));
        end
        wdata_sh = bus.i_req_wdata << {eff_off, 3'b000};
    end

    // Load path: shift the addressed bytes down, then sign- or zero-extend above the access size.
    always_comb begin
        rword    = mem[word_idx[DEPTH_W-1:0]];
        rword_sh = rword >> {eff_off, 3'b000};
        sign_bit = 1'b0;
        for (int l = 0; l < int'(LANES); l++) begin
            if (l + 1 == int'(nbytes)) begin
                sign_bit = rword_sh[8*l + 7];
            end
        end
        fill      = sign_bit && !bus.i_req_unsigned;
        load_data = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            load_data[8*l +: 8] = (l < int'(nbytes)) ? rword_sh[8*l +: 8] : {8{fill}};
        end
    end

    assign accept = bus.i_req_valid && bus.o_req_ready;
    assign wr_en  = accept && bus.i_req_we && !fault && !reset;

    // Storage array: byte-lane writes, no reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (lane_en[l]) begin
                    mem[word_idx[DEPTH_W-1:0]][8*l +: 8] <= wdata_sh[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; ready whenever the held response leaves this cycle.
    always_comb begin
        state_next      = state;
        bus.o_req_ready = (state == IDLE) || bus.i_rsp_ready;
        bus.o_rsp_valid = (state == FULL);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (bus.i_rsp_ready && !accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Response payload register; only loaded on accept so it holds under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_rdata <= (fault || bus.i_req_we) ? '0 : load_data;
            rsp_err   <= fault;
        end
    end

    assign bus.o_rsp_rdata = rsp_rdata;
    assign bus.o_rsp_err   = rsp_err;
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed requests push expected responses,
// a monitor pops and compares on each consumed response and checks latency and hold.
module tb_data_memory;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_if #(.DATA_WIDTH_P(DW), .ADDR_WIDTH_P(AW)) bus ();

    data_memory #(
        .DATA_WIDTH_P(DW),
        .ADDR_WIDTH_P(AW),
        .DEPTH_P     (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    rsp_t exp_q[$];
    int   acc_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=none required=event", name);
    endtask

    // Present one request, wait for its accept (bounded), then record the expected response.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         input logic [31:0] er, input logic ee);
        logic rdy;
        int   n;
        rsp_t e;
        n                  = 0;
        bus.i_req_valid    = 1'b1;
        bus.i_req_we       = we;
        bus.i_req_addr     = addr;
        bus.i_req_size     = size;
        bus.i_req_unsigned = uns;
        bus.i_req_wdata    = wdata;
        forever begin
            @(negedge clk);
            rdy = bus.o_req_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 50) begin
                fail_now("accept_timeout");
                break;
            end
        end
        e.rdata = er;
        e.err   = ee;
        if (rdy) exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.i_req_valid = 1'b0;
        bus.i_req_we    = 1'b0;
    endtask

    // Monitor: latency of each new response, stability while held, in-order scoreboard compare.
    logic        pv, pr, he;
    logic [31:0] hd;
    initial begin : monitor
        rsp_t e;
        int   a;
        pv = 1'b0;
        pr = 1'b0;
        hd = '0;
        he = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 32'(bus.o_rsp_valid), 32'd1);
                    chk("hold_rdata", bus.o_rsp_rdata, hd);
                    chk("hold_err", 32'(bus.o_rsp_err), 32'(he));
                end
                if (bus.o_rsp_valid && (!pv || pr)) begin
                    if (acc_q.size() == 0) fail_now("response_without_accept");
                    else begin
                        a = acc_q.pop_front();
                        chk("latency", 32'(cyc), 32'(a + 1));
                    end
                end
                if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_response");
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", bus.o_rsp_rdata, e.rdata);
                        chk("rsp_err", 32'(bus.o_rsp_err), 32'(e.err));
                    end
                end
                if (bus.i_req_valid && bus.o_req_ready) acc_q.push_back(cyc);
                pv = bus.o_rsp_valid;
                pr = bus.i_rsp_ready;
                hd = bus.o_rsp_rdata;
                he = bus.o_rsp_err;
            end
        end
    end

    initial begin : driver
        reset              = 1'b1;
        bus.i_rsp_ready    = 1'b1;
        bus.i_req_addr     = '0;
        bus.i_req_size     = 2'd0;
        bus.i_req_unsigned = 1'b0;
        bus.i_req_wdata    = '0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("reset_rsp_rdata", bus.o_rsp_rdata, 32'h0);
        chk("reset_rsp_err", 32'(bus.o_rsp_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_req_ready", 32'(bus.o_req_ready), 32'd1);

        // Word round trip, byte store, sign/zero extension, halfwords.
        issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        issue(1'b1, 32'h13, 2'd0, 1'b0, 32'h00000080, 32'h0, 1'b0);
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
        issue(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
        issue(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 32'h00000080, 1'b0);
        issue(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 32'hFFFF80AD, 1'b0);
        issue(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 32'h000080AD, 1'b0);
`ifdef DATA_MEMORY_MISALIGN_ERR_EN
        issue(1'b0, 32'h11, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1);
`else
        issue(1'b0, 32'h11, 2'd1, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0);
`endif
        issue(1'b0, 32'h10, 2'd0, 1'b1, 32'h0, 32'h000000EF, 1'b0);
        issue(1'b0, 32'h11, 2'd0, 1'b0, 32'h0, 32'hFFFFFFBE, 1'b0);

        // Lane masking: upper wdata bytes must not leak into neighbouring lanes.
        issue(1'b1, 32'h16, 2'd1, 1'b0, 32'hFFFF1234, 32'h0, 1'b0);
        issue(1'b1, 32'h14, 2'd0, 1'b0, 32'hAAAAAA56, 32'h0, 1'b0);
        issue(1'b1, 32'h15, 2'd0, 1'b0, 32'h12345678, 32'h0, 1'b0);
        issue(1'b0, 32'h14, 2'd2, 1'b0, 32'h0, 32'h12347856, 1'b0);
        issue(1'b0, 32'h16, 2'd1, 1'b1, 32'h0, 32'h00001234, 1'b0);

        // Read-after-write on consecutive cycles.
        issue(1'b1, 32'h20, 2'd2, 1'b0, 32'h01020304, 32'h0, 1'b0);
        issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 32'h01020304, 1'b0);

        // Out of range and illegal size: fault, no write.
        issue(1'b1, 32'h0, 2'd2, 1'b0, 32'hA5A5A5A5, 32'h0, 1'b0);
        issue(1'b1, 32'h1000, 2'd2, 1'b0, 32'h11111111, 32'h0, 1'b1);
        issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0);
        issue(1'b0, 32'h2000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 32'h0, 2'd3, 1'b0, 32'h22222222, 32'h0, 1'b1);
        issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: consumer stalls for two cycles while three loads are queued.
        bus.i_rsp_ready = 1'b0;
        fork
            begin
                issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
                issue(1'b0, 32'h14, 2'd2, 1'b0, 32'h0, 32'h12347856, 1'b0);
                issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 32'h01020304, 1'b0);
            end
            begin
                @(posedge clk);
                @(negedge clk);
                chk("bp_req_ready_low", 32'(bus.o_req_ready), 32'd0);
                chk("bp_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
                @(posedge clk);
                #1;
                bus.i_rsp_ready = 1'b1;
            end
        join
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset while a response is held; a store presented during reset must not land.
        bus.i_rsp_ready = 1'b0;
        issue(1'b0, 32'h14, 2'd2, 1'b0, 32'h0, 32'h12347856, 1'b0);
        idle();
        @(posedge clk);
        #1;
        chk("held_before_reset", 32'(bus.o_rsp_valid), 32'd1);
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = 1'b1;
        bus.i_req_addr  = 32'h10;
        bus.i_req_size  = 2'd2;
        bus.i_req_wdata = 32'h0;
        reset           = 1'b1;
        #1;
        chk("reset_drops_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("reset_clears_rdata", bus.o_rsp_rdata, 32'h0);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        idle();
        bus.i_rsp_ready = 1'b1;
        reset           = 1'b0;
        chk("post_reset_req_ready", 32'(bus.o_req_ready), 32'd1);
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
        idle();
        repeat (4) @(posedge clk);
        #1;
        chk("final_drained", 32'(exp_q.size()), 32'd0);
        chk("final_accepts_matched", 32'(acc_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
